// File: rtl/pong_pkg.sv
// pong_pkg: shared FSM encodings and playfield geometry for the pong blocks.
package pong_pkg;
  typedef enum logic [1:0] {SERVE, PLAY, LOST} state_t;
  localparam int SCREEN_WIDTH = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int PADDLE_WIDTH = 64;
  localparam int PADDLE_Y = 440;
  localparam int BALL_SIZE = 8;
  localparam logic [22:0] SPEED_DIV = 23'd1_666_666;
endpackage

// File: rtl/tick_divider.sv
// tick_divider: free-running 0..TC counter with enable and sync clear; tick on terminal count.
module tick_divider #(
  parameter int W = 23,
  parameter logic [W-1:0] TC = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  logic [W-1:0] div;
  assign tick = en && div == TC;
  always_ff @(posedge clk or posedge rst)
    if (rst) div <= '0;
    else div <= clr ? '0 : tick ? '0 : en ? div + 1'b1 : div;
endmodule

// File: rtl/ball_physics.sv
// ball_physics: ball motion, wall/paddle reflection, loss detection and hit counting.
module ball_physics import pong_pkg::*; #(
  parameter int SCREEN_WIDTH = pong_pkg::SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = pong_pkg::SCREEN_HEIGHT,
  parameter int BALL_SIZE = pong_pkg::BALL_SIZE,
  parameter int PADDLE_WIDTH = pong_pkg::PADDLE_WIDTH,
  parameter int SPEED = 2,
  parameter logic [22:0] SPEED_DIV = pong_pkg::SPEED_DIV,
  parameter int START_X = 316,
  parameter int START_Y = 236,
  parameter bit START_DX_RIGHT = 1'b1,
  parameter bit START_DY_DOWN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] paddle_x,
  input  logic [15:0] paddle_y,
  output logic [15:0] ball_x,
  output logic [15:0] ball_y,
  output logic        lose,
  output logic [7:0]  hit_count,
  output logic        bounce
);
  localparam logic [16:0] SW = 17'(SCREEN_WIDTH), SH = 17'(SCREEN_HEIGHT);
  localparam logic [16:0] BS = 17'(BALL_SIZE), SP = 17'(SPEED), PW = 17'(PADDLE_WIDTH);
  localparam logic [15:0] SX = 16'(START_X), SY = 16'(START_Y);
  state_t state, next_state;
  logic dx, dy, tick, en, clr;
  logic [16:0] x, y, px, py;
  logic hx_r, hx_l, hit, floor_hit, top_hit, side, vref, lost_now;
  logic [15:0] nx, ny;
  tick_divider #(.W(23), .TC(SPEED_DIV)) u_div (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .tick(tick)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= SERVE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    if (state == SERVE && start) next_state = PLAY;
    else if (state == PLAY && tick && lost_now) next_state = LOST;
    else if (state == LOST && start) next_state = SERVE;
  end
  always_comb begin
    en = state == PLAY;
    clr = state == SERVE;
  end
  // 17-bit sums keep edge tests free of 16-bit wraparound
  always_comb begin
    x = {1'b0, ball_x};
    y = {1'b0, ball_y};
    px = {1'b0, paddle_x};
    py = {1'b0, paddle_y};
    hx_r = x + BS + SP >= SW;
    hx_l = x <= SP;
    hit = (y + BS <= py) && (y + BS + SP >= py) && (x + BS > px) && (x < px + PW);
    floor_hit = !hit && (y + BS + SP >= SH);
    top_hit = y <= SP;
    side = dx ? hx_r : hx_l;
    vref = dy ? hit : top_hit;
    lost_now = dy && floor_hit;
    nx = dx ? (hx_r ? 16'(SW - BS) : 16'(x + SP)) : (hx_l ? 16'd0 : 16'(x - SP));
    ny = dy ? (hit ? 16'(py - BS) : floor_hit ? 16'(SH - BS) : 16'(y + SP))
            : (top_hit ? 16'd0 : 16'(y - SP));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ball_x <= SX;
      ball_y <= SY;
      dx <= START_DX_RIGHT;
      dy <= START_DY_DOWN;
      lose <= 1'b0;
      hit_count <= 8'd0;
      bounce <= 1'b0;
    end else begin
      lose <= next_state == LOST;
      bounce <= 1'b0;
      if (state == LOST && start) begin
        ball_x <= SX;
        ball_y <= SY;
        dx <= START_DX_RIGHT;
        dy <= START_DY_DOWN;
        hit_count <= 8'd0;
      end else if (tick) begin
        ball_x <= nx;
        ball_y <= ny;
        dx <= dx ^ side;
        dy <= dy ^ vref;
        if (dy && hit && hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
        bounce <= (side || vref) && !lost_now;
      end
    end
endmodule

// File: tb/tb_ball_physics.sv
// tb_ball_physics: directed checks of serve, walls, paddle hit, miss/restart and async reset.
module tb_ball_physics;
  logic clk = 0, rst = 1;
  logic sa = 0, sb = 0, sc = 0, sd = 0;
  logic [15:0] ax, ay, bx, by, cx, cy, dxo, dyo;
  logic al, bl, cl, dl, ab, bb, cb, db;
  logic [7:0] ah, bh, ch, dh;
  int n_cmp = 0, n_err = 0;
  int cnt_a = 0, cnt_b = 0, cnt_c = 0, cnt_d = 0;
  always #5 clk = ~clk;

  ball_physics #(.SPEED_DIV(23'd3)) u_a (
    .clk(clk), .rst(rst), .start(sa), .paddle_x(16'd0), .paddle_y(16'd440),
    .ball_x(ax), .ball_y(ay), .lose(al), .hit_count(ah), .bounce(ab));
  ball_physics #(.SPEED_DIV(23'd3), .START_X(626)) u_b (
    .clk(clk), .rst(rst), .start(sb), .paddle_x(16'd0), .paddle_y(16'd440),
    .ball_x(bx), .ball_y(by), .lose(bl), .hit_count(bh), .bounce(bb));
  ball_physics #(.SPEED_DIV(23'd3), .START_X(300), .START_Y(428), .START_DY_DOWN(1'b1)) u_c (
    .clk(clk), .rst(rst), .start(sc), .paddle_x(16'd300), .paddle_y(16'd440),
    .ball_x(cx), .ball_y(cy), .lose(cl), .hit_count(ch), .bounce(cb));
  ball_physics #(.SPEED_DIV(23'd3), .START_X(400), .START_DY_DOWN(1'b1)) u_d (
    .clk(clk), .rst(rst), .start(sd), .paddle_x(16'd0), .paddle_y(16'd440),
    .ball_x(dxo), .ball_y(dyo), .lose(dl), .hit_count(dh), .bounce(db));

  always @(negedge clk)
    if (rst) begin
      cnt_a <= 0; cnt_b <= 0; cnt_c <= 0; cnt_d <= 0;
    end else begin
      cnt_a <= cnt_a + int'(ab); cnt_b <= cnt_b + int'(bb);
      cnt_c <= cnt_c + int'(cb); cnt_d <= cnt_d + int'(db);
    end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cyc(3);
    rst = 0;
    cyc(1);
    check("rst_x", ax, 316); check("rst_y", ay, 236); check("rst_lose", al, 0);
    check("rst_hit", ah, 0); check("rst_bounce", ab, 0);
    cyc(100);
    check("idle_x", ax, 316); check("idle_y", ay, 236); check("idle_bx", bx, 626);
    sa = 1; sb = 1; sc = 1; sd = 1;
    cyc(1);
    sa = 0; sb = 0; sc = 0; sd = 0;
    cyc(3);
    check("pre_tick_x", ax, 316);
    cyc(1);
    check("t1_ax", ax, 318); check("t1_ay", ay, 234); check("t1_bx", bx, 628);
    check("t1_cy", cy, 430); check("t1_dy", dyo, 238); check("t1_dx", dxo, 402);
    cyc(4);
    check("t2_ax", ax, 320); check("t2_ay", ay, 232); check("t2_bx", bx, 630);
    check("t2_cy", cy, 432); check("t2_chit", ch, 1); check("t2_cbounce", cb, 1);
    cyc(1);
    check("t2_cbounce_end", cb, 0);
    cyc(3);
    check("t3_bx", bx, 632); check("t3_bbounce", bb, 1); check("t3_cy", cy, 430);
    cyc(4);
    check("t4_bx", bx, 630); check("b_bounce_cnt", cnt_b, 1);
    check("c_bounce_cnt", cnt_c, 1); check("a_bounce_cnt", cnt_a, 0);
    for (int i = 0; i < 1000 && !dl; i++) @(negedge clk);
    check("d_lose", dl, 1); check("d_y", dyo, 472); check("d_x", dxo, 628);
    check("d_hit", dh, 0); check("d_bounce_cnt", cnt_d, 1);
    cyc(50);
    check("d_frozen_x", dxo, 628); check("d_frozen_y", dyo, 472); check("d_lose_hold", dl, 1);
    check("d_bounce_cnt2", cnt_d, 1);
    sd = 1;
    cyc(1);
    sd = 0;
    check("d_restart_lose", dl, 0); check("d_restart_x", dxo, 400);
    check("d_restart_y", dyo, 236); check("d_restart_hit", dh, 0);
    cyc(20);
    check("d_serve_hold", dyo, 236);
    sa = 1;
    cyc(1);
    sa = 0;
    cyc(2);
    #2 rst = 1;
    #1;
    check("arst_x", ax, 316); check("arst_y", ay, 236); check("arst_lose", al, 0);
    check("arst_bounce", ab, 0); check("arst_chit", ch, 0); check("arst_cy", cy, 428);
    cyc(2);
    rst = 0;
    cyc(20);
    check("post_rst_x", ax, 316); check("post_rst_y", ay, 236);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
